// File: rtl/dataflow_proc_stall_filter.sv
// Per-process stall qualifier: debounces raw per-channel blocked indications and
// counts start/done transactions for the deadlock-detection fabric.
module dataflow_proc_stall_filter #(
    parameter int unsigned NUM_CHAN     = 2,
    parameter int unsigned STALL_THRESH = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start_write,
    input  logic                ap_done,
    input  logic                ap_continue,
    input  logic [NUM_CHAN-1:0] chan_blk,
    input  logic                hold,
    output logic [NUM_CHAN-1:0] proc_dep_vld_vec,
    output logic [CNT_W-1:0]    trans_in_cnt,
    output logic [CNT_W-1:0]    trans_out_cnt,
    output logic                in_flight,
    output logic [1:0]          state_o
);

    localparam int unsigned SCNT_W = $clog2(STALL_THRESH + 1);
    localparam logic [SCNT_W-1:0] THRESH = SCNT_W'(STALL_THRESH);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StStall  = 2'd2,
        StFrozen = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    tin_q, tin_d, tout_q, tout_d;
    logic                inflight_q, inflight_d;
    logic [SCNT_W-1:0]   scnt_q [NUM_CHAN];
    logic [SCNT_W-1:0]   scnt_d [NUM_CHAN];
    logic [NUM_CHAN-1:0] qual_d, vld_q, vld_d;

    always_comb begin
        tin_d      = tin_q + CNT_W'(start_write);
        tout_d     = tout_q + CNT_W'(ap_done & ap_continue);
        inflight_d = (tin_d != tout_d);
    end

    // Stall counters saturate at the threshold so a long block never wraps back to unqualified.
    always_comb begin
        for (int i = 0; i < NUM_CHAN; i++) begin
            scnt_d[i] = scnt_q[i];
            if (!hold) begin
                if (chan_blk[i]) begin
                    if (scnt_q[i] != THRESH) begin
                        scnt_d[i] = scnt_q[i] + SCNT_W'(1);
                    end
                end else begin
                    scnt_d[i] = '0;
                end
            end
            qual_d[i] = (scnt_d[i] == THRESH) & ~hold;
        end
        vld_d = hold ? vld_q : qual_d;
    end

    always_comb begin
        state_d = state_q;
        if (hold) begin
            state_d = StFrozen;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A simultaneous start and completion leaves the process idle.
                    if (start_write && inflight_d) state_d = StActive;
                end
                StActive: begin
                    if (|qual_d)                         state_d = StStall;
                    else if (!inflight_d && !start_write) state_d = StIdle;
                end
                StStall: begin
                    if (!(|qual_d)) state_d = inflight_d ? StActive : StIdle;
                end
                StFrozen: begin
                    if (|qual_d)         state_d = StStall;
                    else if (inflight_d) state_d = StActive;
                    else                 state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            tin_q      <= '0;
            tout_q     <= '0;
            inflight_q <= 1'b0;
            vld_q      <= '0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                scnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            tin_q      <= tin_d;
            tout_q     <= tout_d;
            inflight_q <= inflight_d;
            vld_q      <= vld_d;
            for (int i = 0; i < NUM_CHAN; i++) begin
                scnt_q[i] <= scnt_d[i];
            end
        end
    end

    assign proc_dep_vld_vec = vld_q;
    assign trans_in_cnt     = tin_q;
    assign trans_out_cnt    = tout_q;
    assign in_flight        = inflight_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_dataflow_proc_stall_filter.sv
// Scoreboard bench: directed stimulus pushes hand-computed expectations, a monitor pops and
// compares them one clock later. A second instance (CNT_W=4, STALL_THRESH=1) covers wrap/thresh-1.
module tb_dataflow_proc_stall_filter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset = 1'b1, start_write = 1'b0, ap_done = 1'b0, ap_continue = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] chan_blk = 2'b00;

    logic [1:0]  vec_a, st_a, vec_b, st_b;
    logic [15:0] tin_a, tout_a;
    logic [3:0]  tin_b, tout_b;
    logic        inf_a, inf_b;

    dataflow_proc_stall_filter #(.NUM_CHAN(2), .STALL_THRESH(16), .CNT_W(16)) u_dut_a (
        .clock(clock), .reset(reset), .start_write(start_write), .ap_done(ap_done),
        .ap_continue(ap_continue), .chan_blk(chan_blk), .hold(hold),
        .proc_dep_vld_vec(vec_a), .trans_in_cnt(tin_a), .trans_out_cnt(tout_a),
        .in_flight(inf_a), .state_o(st_a)
    );

    dataflow_proc_stall_filter #(.NUM_CHAN(2), .STALL_THRESH(1), .CNT_W(4)) u_dut_b (
        .clock(clock), .reset(reset), .start_write(start_write), .ap_done(ap_done),
        .ap_continue(ap_continue), .chan_blk(chan_blk), .hold(hold),
        .proc_dep_vld_vec(vec_b), .trans_in_cnt(tin_b), .trans_out_cnt(tout_b),
        .in_flight(inf_b), .state_o(st_b)
    );

    typedef struct {
        string       name;
        int          target;
        bit          dut;
        bit          m_vec;
        logic [1:0]  vec;
        bit          m_cnt;
        logic [15:0] tin;
        logic [15:0] tout;
        logic        inf;
        bit          m_st;
        logic [1:0]  st;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic push(input string nm, input bit dut, input bit mv, input logic [1:0] v,
                        input bit mc, input int ti, input int to, input logic inf,
                        input bit ms, input logic [1:0] st);
        exp_t e;
        e.name = nm;  e.target = cyc + 1; e.dut = dut;
        e.m_vec = mv; e.vec = v;
        e.m_cnt = mc; e.tin = 16'(ti); e.tout = 16'(to); e.inf = inf;
        e.m_st = ms;  e.st = st;
        sb.push_back(e);
    endtask

    task automatic chk_all(input string nm, input bit dut, input logic [1:0] v, input int ti,
                           input int to, input logic inf, input logic [1:0] st);
        push(nm, dut, 1'b1, v, 1'b1, ti, to, inf, 1'b1, st);
    endtask

    task automatic chk_vs(input string nm, input bit dut, input logic [1:0] v,
                          input logic [1:0] st);
        push(nm, dut, 1'b1, v, 1'b0, 0, 0, 1'b0, 1'b1, st);
    endtask

    task automatic chk_v(input string nm, input bit dut, input logic [1:0] v);
        push(nm, dut, 1'b1, v, 1'b0, 0, 0, 1'b0, 1'b0, 2'd0);
    endtask

    // Inputs change on the falling edge; expectations pushed afterwards target the next rise.
    task automatic tick(input logic rst, input logic sw, input logic dc, input logic [1:0] blk,
                        input logic h);
        @(negedge clock);
        reset = rst; start_write = sw; ap_done = dc; ap_continue = dc;
        chan_blk = blk; hold = h;
    endtask

    // Monitor
    initial begin
        exp_t        e;
        logic [1:0]  av, ast;
        logic [15:0] ati, ato;
        logic        ainf;
        bit          bad;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].target <= cyc) begin
                e = sb.pop_front();
                if (e.dut) begin
                    av = vec_b; ati = {12'd0, tin_b}; ato = {12'd0, tout_b};
                    ainf = inf_b; ast = st_b;
                end else begin
                    av = vec_a; ati = tin_a; ato = tout_a; ainf = inf_a; ast = st_a;
                end
                bad = (e.m_vec && (av !== e.vec)) ||
                      (e.m_cnt && ((ati !== e.tin) || (ato !== e.tout) || (ainf !== e.inf))) ||
                      (e.m_st && (ast !== e.st));
                n_cmp++;
                if (bad) begin
                    n_bad++;
                    $display("FAIL %s cyc%0d: got vec=%b in=%0d out=%0d inf=%b st=%0d, want vec=%b in=%0d out=%0d inf=%b st=%0d",
                             e.name, cyc, av, ati, ato, ainf, ast,
                             e.vec, e.tin, e.tout, e.inf, e.st);
                end
            end
        end
    end

    initial begin
        // Reset with channels blocked, then first qualification 16 edges after release
        tick(1, 0, 0, 2'b11, 0);
        tick(1, 0, 0, 2'b11, 0);
        chk_all("rst_a", 0, 2'b00, 0, 0, 0, 2'd0);
        chk_all("rst_b", 1, 2'b00, 0, 0, 0, 2'd0);
        for (int i = 1; i <= 16; i++) begin
            tick(0, 0, 0, 2'b11, 0);
            if (i == 1)  chk_v("thresh1_b", 1, 2'b11);
            if (i == 15) chk_v("rst_pre16", 0, 2'b00);
            if (i == 16) chk_vs("rst_q16", 0, 2'b11, 2'd0);
        end
        tick(0, 0, 0, 2'b00, 0);
        chk_v("unblock", 0, 2'b00);

        // Debounce with one transaction in flight
        tick(0, 1, 0, 2'b00, 0);
        chk_all("sw1", 0, 2'b00, 1, 0, 1, 2'd1);
        for (int i = 1; i <= 15; i++) begin
            tick(0, 0, 0, 2'b01, 0);
            if (i == 1)  chk_vs("thresh1_stall_b", 1, 2'b01, 2'd2);
            if (i == 15) chk_vs("deb15", 0, 2'b00, 2'd1);
        end
        tick(0, 0, 0, 2'b00, 0);
        chk_vs("deb_drop", 0, 2'b00, 2'd1);
        for (int i = 1; i <= 16; i++) begin
            tick(0, 0, 0, 2'b01, 0);
            if (i == 15) chk_vs("deb15b", 0, 2'b00, 2'd1);
            if (i == 16) chk_vs("deb16", 0, 2'b01, 2'd2);
        end
        tick(0, 0, 0, 2'b00, 0);
        chk_vs("deb_release", 0, 2'b00, 2'd1);

        // Counter handshakes
        tick(1, 0, 0, 2'b00, 0);
        chk_all("rst2", 0, 2'b00, 0, 0, 0, 2'd0);
        tick(0, 1, 0, 2'b00, 0);
        chk_all("cnt1", 0, 2'b00, 1, 0, 1, 2'd1);
        tick(0, 1, 1, 2'b00, 0);
        chk_all("cnt2_both", 0, 2'b00, 2, 1, 1, 2'd1);
        tick(0, 1, 0, 2'b00, 0);
        chk_all("cnt3", 0, 2'b00, 3, 1, 1, 2'd1);
        tick(0, 0, 1, 2'b00, 0);
        ap_continue = 1'b0;
        chk_all("done_nocont", 0, 2'b00, 3, 1, 1, 2'd1);
        tick(0, 0, 1, 2'b00, 0);
        chk_all("cnt4", 0, 2'b00, 3, 2, 1, 2'd1);
        tick(0, 0, 1, 2'b00, 0);
        chk_all("cnt5_idle", 0, 2'b00, 3, 3, 0, 2'd0);
        tick(0, 1, 1, 2'b00, 0);
        chk_all("idle_sw_dc", 0, 2'b00, 4, 4, 0, 2'd0);

        // Hold freeze with bit1 qualified
        tick(0, 1, 0, 2'b00, 0);
        chk_all("sw5", 0, 2'b00, 5, 4, 1, 2'd1);
        for (int i = 1; i <= 16; i++) begin
            tick(0, 0, 0, 2'b10, 0);
            if (i == 16) chk_vs("q_bit1", 0, 2'b10, 2'd2);
        end
        for (int i = 1; i <= 5; i++) begin
            tick(0, logic'(i == 3), 0, 2'b00, 1);
            chk_vs("hold_frozen", 0, 2'b10, 2'd3);
            if (i == 3) chk_all("hold_counts", 0, 2'b10, 6, 4, 1, 2'd3);
        end
        tick(0, 0, 0, 2'b00, 0);
        chk_vs("unhold", 0, 2'b00, 2'd1);

        // Interrupted block restarts the count and never qualifies
        for (int i = 0; i <= 20; i++) begin
            tick(0, 0, 0, (i == 10) ? 2'b00 : 2'b01, 0);
            chk_vs("interrupted", 0, 2'b00, 2'd1);
        end
        tick(0, 0, 0, 2'b00, 0);

        // Mid-stall reset, asserted together with hold
        for (int i = 1; i <= 16; i++) begin
            tick(0, 0, 0, 2'b11, 0);
            if (i == 16) chk_vs("q_both", 0, 2'b11, 2'd2);
        end
        tick(1, 0, 0, 2'b11, 1);
        chk_all("midrst", 0, 2'b00, 0, 0, 0, 2'd0);
        for (int i = 1; i <= 16; i++) begin
            tick(0, 0, 0, 2'b11, 0);
            if (i == 15) chk_v("requal15", 0, 2'b00);
            if (i == 16) chk_vs("requal16", 0, 2'b11, 2'd0);
        end

        // Counter wrap on the 4-bit instance: 17 in and 17 out
        tick(1, 0, 0, 2'b00, 0);
        for (int i = 1; i <= 15; i++) begin
            tick(0, 1, 1, 2'b00, 0);
            if (i == 15) chk_all("wrap15_b", 1, 2'b00, 15, 15, 0, 2'd0);
        end
        tick(0, 1, 0, 2'b00, 0);
        chk_all("wrap_in_b", 1, 2'b00, 0, 15, 1, 2'd1);
        chk_all("wrap_in_a", 0, 2'b00, 16, 15, 1, 2'd1);
        tick(0, 0, 1, 2'b00, 0);
        chk_all("wrap_out_b", 1, 2'b00, 0, 0, 0, 2'd0);
        chk_all("wrap_out_a", 0, 2'b00, 16, 16, 0, 2'd0);
        tick(0, 1, 1, 2'b00, 0);
        chk_all("wrap17_b", 1, 2'b00, 1, 1, 0, 2'd0);
        chk_all("wrap17_a", 0, 2'b00, 17, 17, 0, 2'd0);

        tick(0, 0, 0, 2'b00, 0);
        tick(0, 0, 0, 2'b00, 0);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dataflow_proc_stall_filter.md
Name: dataflow_proc_stall_filter

Overview:
- Per-process stall qualifier for the cosim deadlock-detection fabric.
- Sits directly upstream of the per-process deadlock detect unit: it takes one process's raw per-channel blocked indications and handshake strobes, and produces the debounced proc_dep_vld_vec plus the trans_in/trans_out transaction counters the report unit consumes.
- It filters transient back-pressure, so the detector only sees channels blocked for STALL_THRESH consecutive cycles.

Parameters:
- NUM_CHAN, 2: number of dependency channels (output dependency vector width).
- STALL_THRESH, 16: consecutive blocked cycles required to qualify a channel; legal range 1..255.
- CNT_W, 16: width of the transaction counters.

Ports:
- clock  in  1  design clock.
- reset  in  1  synchronous, active-high reset.
- start_write  in  1  process start-token write strobe; one transaction in.
- ap_done  in  1  process done.
- ap_continue  in  1  downstream continue; done&continue is one transaction out.
- chan_blk  in  NUM_CHAN  raw per-channel blocked (OR of ~blk_n terms and start-FIFO terms), 1 = blocked.
- hold  in  1  freeze request from the deadlock report unit (dl_detect_out).
- proc_dep_vld_vec  out  NUM_CHAN  qualified per-channel dependency valid.
- trans_in_cnt  out  CNT_W  transactions started.
- trans_out_cnt  out  CNT_W  transactions completed.
- in_flight  out  1  1 when trans_in_cnt != trans_out_cnt.
- state_o  out  2  FSM state: 0 IDLE, 1 ACTIVE, 2 STALL, 3 FROZEN.

Behaviour:
- Clock and reset: one clock, `clock`; `reset` is synchronous and active-high, sampled on the rising edge of `clock`.
- Reset values: all outputs 0; state IDLE; per-channel stall counters 0. Reset mid-operation overrides every other event in that cycle, including hold.

Transaction counters:
- trans_in_cnt increments on start_write.
- trans_out_cnt increments on ap_done & ap_continue.
- Both may increment in the same cycle.
- Both wrap modulo 2^CNT_W.
- in_flight is registered, computed from the next-state counter values; it has the same latency as the counters.

Per-channel stall counter scnt[i] (width ceil(log2(STALL_THRESH+1))):
- If hold = 1: scnt frozen.
- Else if chan_blk[i] = 1: scnt[i] <= min(scnt[i]+1, STALL_THRESH). It saturates and never wraps.
- Else: scnt[i] <= 0.

Qualification:
- Registered: qual[i] = (scnt_next[i] == STALL_THRESH) & ~hold.
- proc_dep_vld_vec[i] rises on the clock edge that ends the STALL_THRESH-th consecutive blocked cycle. Latency is STALL_THRESH cycles from the first blocked sample.
- It falls on the edge after chan_blk[i] first deasserts (1-cycle latency).

Hold:
- While hold = 1, proc_dep_vld_vec keeps its last value, regardless of chan_blk.
- Counters trans_in/out continue to count during hold, because handshakes are still real.

FSM (registered; priority order top to bottom):
- Any state with hold = 1: go to FROZEN.
- FROZEN with hold = 0: go to STALL if any qual, else ACTIVE if in_flight, else IDLE.
- IDLE: go to ACTIVE on start_write.
- ACTIVE: go to STALL if any qual. Otherwise go to IDLE when the counters become equal and no start_write occurs in that cycle.
- STALL: go to ACTIVE when all qual = 0 and in_flight. Go to IDLE when all qual = 0 and !in_flight.
- start_write and done&continue in the same cycle while IDLE: stay ACTIVE only if the counters differ afterward.

Boundary cases:
- chan_blk toggling 1-0-1 restarts the count from 0 and never qualifies.
- STALL_THRESH = 1: a channel qualifies on the first blocked edge.
- With trans_out_cnt at all-ones, a completion wraps it to 0 and in_flight is still computed correctly by inequality.

Test Plan:
- Reset check: assert reset for 2 cycles with chan_blk = 2'b11 → all outputs 0, state_o = 0; the first qualification occurs exactly 16 cycles after reset deasserts.
- Debounce: chan_blk[0] = 1 for 15 cycles, then 0 → proc_dep_vld_vec stays 2'b00. Held for 16 cycles → bit0 = 1 on the 16th edge, state_o = 2; release → bit0 = 0 one cycle later, state_o = 1.
- Counter handshakes: 3 start_write pulses and 1 done&continue, with one cycle having both simultaneously → trans_in_cnt = 3, trans_out_cnt = 1, in_flight = 1. Complete the remaining two → in_flight = 0, state_o = 0.
- Hold freeze: with bit1 qualified, assert hold and drop chan_blk[1] for 5 cycles → proc_dep_vld_vec = 2'b10 and state_o = 3 throughout. Deassert hold → vector 2'b00 and state_o = 1 next cycle.
- Wrap: CNT_W = 4, 17 transactions in and out → both counters read 1, in_flight = 0.
- Mid-stall reset: qualified stall on both channels, reset pulsed for 1 cycle → vector 0 and scnt 0; a continued block requalifies only after 16 more cycles.
